// File: rtl/uart_apb_pkg.sv
// Shared types and UART register map for the APB requester.
package uart_apb_pkg;

  // Transfer phases of the APB requester
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // UART register map as seen on the APB slave port of uart_top
  localparam logic [7:0] ADDR_RXFIFO = 8'h00;  // read pops the RX FIFO
  localparam logic [7:0] ADDR_DIVXR  = 8'h01;
  localparam logic [7:0] ADDR_TXFIFO = 8'h02;

endpackage : uart_apb_pkg

// File: rtl/uart_apb_master.sv
// APB3 requester: takes one read/write command at a time on a valid/ready
// stream, runs SETUP/ACCESS with wait-state and timeout handling, and returns
// read data plus error status on a valid/ready response stream.
module uart_apb_master
  import uart_apb_pkg::*;
#(
  parameter int APB_DW  = 8,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200   // 0 disables the abort; must be < 2**TO_W
) (
  input  logic              clk,
  input  logic              rst,          // synchronous, active low
  // command stream
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [APB_DW-1:0] cmd_addr,
  input  logic [APB_DW-1:0] cmd_wdata,
  // response stream
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [APB_DW-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  // APB requester port
  output logic [APB_DW-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [APB_DW-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [APB_DW-1:0] PRDATA,
  input  logic              PSLVERR
);

  // Counter value seen in the last ACCESS cycle before the abort fires.
  // Only meaningful when TIMEOUT != 0.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [TO_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic [APB_DW-1:0] paddr_nxt, pwdata_nxt, rsp_rdata_nxt;
  logic              psel_nxt, penable_nxt, pwrite_nxt;
  logic              rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;

  // Only combinational output: ready whenever no transfer is in flight
  assign cmd_ready = (state == IDLE);

  // State and registered outputs; reset drops any transfer in flight
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, independent of statement order.
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      PADDR       <= paddr_nxt;
      PWDATA      <= pwdata_nxt;
      PWRITE      <= pwrite_nxt;
      PSEL        <= psel_nxt;
      PENABLE     <= penable_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
    end
  end

  // Next-state and next-output logic for the transfer sequence
  always_comb begin
    // NOTE: every variable gets a hold-value default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    paddr_nxt       = PADDR;
    pwdata_nxt      = PWDATA;
    pwrite_nxt      = PWRITE;
    psel_nxt        = PSEL;
    penable_nxt     = PENABLE;
    rsp_valid_nxt   = rsp_valid;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;

    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          paddr_nxt   = cmd_addr;
          pwrite_nxt  = cmd_write;
          pwdata_nxt  = cmd_write ? cmd_wdata : '0;  // bus stays quiet on reads
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          state_nxt   = SETUP;
        end
      end

      SETUP: begin
        // Single setup cycle; PREADY is deliberately not looked at here
        penable_nxt  = 1'b1;
        wait_cnt_nxt = '0;
        state_nxt    = ACCESS;
      end

      ACCESS: begin
        if (PREADY) begin
          // Slave completion takes priority over a coincident timeout
          rsp_rdata_nxt   = PWRITE ? '0 : PRDATA;
          rsp_err_nxt     = PSLVERR;
          rsp_timeout_nxt = 1'b0;
          rsp_valid_nxt   = 1'b1;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          state_nxt       = RESP;
        end else if ((TIMEOUT != 0) && (wait_cnt == TO_LAST)) begin
          rsp_rdata_nxt   = '0;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
          rsp_valid_nxt   = 1'b1;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          state_nxt       = RESP;
        end else if (wait_cnt != '1) begin
          // Saturate rather than wrap so a disabled timeout never aliases
          wait_cnt_nxt = wait_cnt + TO_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule : uart_apb_master
